// File: rtl/xor_parity_arb.sv
// Bit-serial even-parity engine: two requesters share one 1-bit XOR cell
// through a round-robin arbiter; the latched word is shifted out LSB-first.

module xor_1 (
  input  logic a,
  input  logic b,
  output logic y
);
  assign y = a ^ b;
endmodule

module xor_parity_arb #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] data0,
  input  logic             req1,
  input  logic [WIDTH-1:0] data1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic             done,
  output logic             parity,
  output logic             src
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic             acc;
  logic             acc_next;
  logic             last;
  logic             cur;
  logic             winner;
  logic             take;
  logic             last_bit;

  xor_1 u_xor (
    .a (acc),
    .b (shreg[0]),
    .y (acc_next)
  );

  assign busy = (state != IDLE);

  // On a tie the requester that was not served most recently wins.
  always_comb begin
    next_state = state;
    take       = 1'b0;
    winner     = 1'b0;
    last_bit   = (cnt == CW'(WIDTH - 1));
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          take       = 1'b1;
          winner     = (req0 && req1) ? ~last : req1;
          next_state = RUN;
        end
      end
      RUN:     if (last_bit) next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg  <= '0;
      cnt    <= '0;
      acc    <= 1'b0;
      cur    <= 1'b0;
      last   <= 1'b1;
      gnt0   <= 1'b0;
      gnt1   <= 1'b0;
      done   <= 1'b0;
      parity <= 1'b0;
      src    <= 1'b0;
    end else begin
      gnt0 <= 1'b0;
      gnt1 <= 1'b0;
      done <= 1'b0;
      if (take) begin
        shreg <= winner ? data1 : data0;
        acc   <= 1'b0;
        cnt   <= '0;
        cur   <= winner;
        gnt0  <= ~winner;
        gnt1  <= winner;
      end else if (state == RUN) begin
        acc   <= acc_next;
        shreg <= shreg >> 1;
        cnt   <= cnt + CW'(1);
        // The last bit's XOR result is the word's parity.
        if (last_bit) begin
          parity <= acc_next;
          src    <= cur;
          last   <= cur;
          done   <= 1'b1;
        end
      end
    end
  end

endmodule
